// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared states, default marker bytes and widths for the serial loader
package serial_loader_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] NACK_BYTE_DEF = 8'hEE;
    localparam logic [ADDR_W-1:0] WORD_STRIDE = 32'd4;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN, S_WAITWR, S_REPLY} rx_state_e;
    typedef enum logic {B_IDLE, B_WRITE} bus_state_e;
endpackage

// File: rtl/serial_loader_bus.sv
// loader_bus_master: one-word holding register, auto-incrementing address and devEnable/devBusy handshake
module loader_bus_master
    import serial_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_addr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              word_valid_i,
    input  logic [DATA_W-1:0] word_i,
    output logic              ready_o,
    input  logic              devBusy_i,
    output logic              devEnable_o,
    output logic [ADDR_W-1:0] devPhysicalAddr_o,
    output logic [DATA_W-1:0] devDataSave_o
);
    bus_state_e        bus_q, bus_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        bus_d = (bus_q == B_WRITE && !devBusy_i) ? B_IDLE : bus_q;
        next_addr_d = set_addr_i ? addr_i : next_addr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (word_valid_i && bus_q == B_IDLE) begin
            bus_d = B_WRITE;
            addr_d = next_addr_q;
            data_d = word_i;
            next_addr_d = next_addr_q + WORD_STRIDE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= B_IDLE;
            next_addr_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            bus_q <= bus_d;
            next_addr_q <= next_addr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign ready_o = bus_q == B_IDLE;
    assign devEnable_o = bus_q == B_WRITE;
    assign devPhysicalAddr_o = addr_q;
    assign devDataSave_o = data_q;
endmodule

// File: rtl/serial_loader.sv
// serial_loader: framed serial bytes to device-bus word writes with checksum reply (optional SERIAL_LOADER_TIMEOUT_EN inter-byte timeout)
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0] NACK_BYTE = NACK_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxdReady_i,
    input  logic [7:0]        rxdData_i,
    input  logic              txdBusy_i,
    output logic              txdStart_o,
    output logic [7:0]        txdData_o,
    output logic              devEnable_o,
    output logic              devWrite_o,
    input  logic              devBusy_i,
    output logic [ADDR_W-1:0] devPhysicalAddr_o,
    output logic [DATA_W-1:0] devDataSave_o,
    output logic [3:0]        devByteSelect_o,
    output logic              active_o,
    output logic              done_o,
    output logic              error_o
);
    rx_state_e        state_q, state_d;
    logic [2:0]       hdr_cnt_q, hdr_cnt_d;
    logic [39:0]      hdr_q, hdr_d;
    logic [23:0]      asm_q, asm_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [CNT_W+1:0] rem_q, rem_d;
    logic [7:0]       csum_q, csum_d;
    logic             err_q, err_d;
    logic             nack_q, nack_d;
    logic [CNT_W-1:0] n_word;
    logic             misaligned, set_addr, word_valid, bus_ready;
`ifdef SERIAL_LOADER_TIMEOUT_EN
    logic [31:0]      tmo_q, tmo_d;
`endif

    assign n_word = {rxdData_i, hdr_q[39:32]};
    assign misaligned = hdr_q[1:0] != 2'b00;

    always_comb begin
        state_d = state_q;
        hdr_cnt_d = hdr_cnt_q;
        hdr_d = hdr_q;
        asm_d = asm_q;
        bcnt_d = bcnt_q;
        rem_d = rem_q;
        csum_d = csum_q;
        err_d = err_q;
        nack_d = nack_q;
        set_addr = 1'b0;
        word_valid = 1'b0;
        case (state_q)
            S_IDLE: if (rxdReady_i && rxdData_i == SYNC_BYTE) begin
                state_d = S_HDR;
                hdr_cnt_d = '0;
                csum_d = '0;
                err_d = 1'b0;
                nack_d = 1'b0;
            end
            S_HDR: if (rxdReady_i) begin
                hdr_cnt_d = hdr_cnt_q + 3'd1;
                hdr_d = {rxdData_i, hdr_q[39:8]};
                if (hdr_cnt_q == 3'd5) begin
                    rem_d = {n_word, 2'b00};
                    bcnt_d = '0;
                    set_addr = !misaligned;
                    err_d = misaligned;
                    nack_d = misaligned;
                    state_d = (n_word == '0) ? S_REPLY : (misaligned ? S_DRAIN : S_DATA);
                end
            end
            S_DATA: if (rxdReady_i) begin
                csum_d = csum_q + rxdData_i;
                rem_d = rem_q - 1'b1;
                bcnt_d = bcnt_q + 2'd1;
                asm_d = {rxdData_i, asm_q[23:8]};
                if (bcnt_q == 2'd3) begin
                    word_valid = bus_ready;
                    err_d = !bus_ready;
                    nack_d = !bus_ready;
                    state_d = (rem_q == 1) ? (bus_ready ? S_WAITWR : S_REPLY)
                                           : (bus_ready ? S_DATA : S_DRAIN);
                end
            end
            S_DRAIN: if (rxdReady_i) begin
                rem_d = rem_q - 1'b1;
                state_d = (rem_q == 1) ? S_REPLY : S_DRAIN;
            end
            S_WAITWR: state_d = bus_ready ? S_REPLY : S_WAITWR;
            S_REPLY: state_d = txdBusy_i ? S_REPLY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef SERIAL_LOADER_TIMEOUT_EN
        tmo_d = (rxdReady_i || state_q == S_IDLE) ? '0 : tmo_q + 32'd1;
        if (tmo_q >= TIMEOUT_CYCLES && (state_q == S_HDR || state_q == S_DATA || state_q == S_DRAIN)) begin
            state_d = S_IDLE;
            err_d = 1'b1;
            set_addr = 1'b0;
            word_valid = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hdr_cnt_q <= '0;
            hdr_q <= '0;
            asm_q <= '0;
            bcnt_q <= '0;
            rem_q <= '0;
            csum_q <= '0;
            err_q <= 1'b0;
            nack_q <= 1'b0;
`ifdef SERIAL_LOADER_TIMEOUT_EN
            tmo_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            hdr_q <= hdr_d;
            asm_q <= asm_d;
            bcnt_q <= bcnt_d;
            rem_q <= rem_d;
            csum_q <= csum_d;
            err_q <= err_d;
            nack_q <= nack_d;
`ifdef SERIAL_LOADER_TIMEOUT_EN
            tmo_q <= tmo_d;
`endif
        end
    end

    loader_bus_master u_bus (
        .clk              (clk),
        .rst              (rst),
        .set_addr_i       (set_addr),
        .addr_i           (hdr_q[31:0]),
        .word_valid_i     (word_valid),
        .word_i           ({rxdData_i, asm_q}),
        .ready_o          (bus_ready),
        .devBusy_i        (devBusy_i),
        .devEnable_o      (devEnable_o),
        .devPhysicalAddr_o(devPhysicalAddr_o),
        .devDataSave_o    (devDataSave_o)
    );

    assign devWrite_o = devEnable_o;
    assign devByteSelect_o = {4{devEnable_o}};
    assign active_o = state_q != S_IDLE;
    assign error_o = err_q;
    assign txdStart_o = state_q == S_REPLY && !txdBusy_i;
    assign txdData_o = (state_q == S_REPLY) ? (nack_q ? NACK_BYTE : csum_q) : 8'h00;
    assign done_o = txdStart_o && !nack_q;
endmodule
